// File: rtl/vend_pkg.sv
// Shared types, coin values and price lookup for the vending front-end.
package vend_pkg;

    typedef logic [3:0] amount_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        REFUND
    } state_t;

    localparam logic [4:0] COIN_1_VAL = 5'd1;
    localparam logic [4:0] COIN_5_VAL = 5'd5;

    // Price of the selected product from the four configured prices.
    function automatic amount_t price_lookup(input logic [1:0] sel,
                                             input amount_t    p0,
                                             input amount_t    p1,
                                             input amount_t    p2,
                                             input amount_t    p3);
        amount_t p;
        p = p0;
        case (sel)
            2'd0: p = p0;
            2'd1: p = p1;
            2'd2: p = p2;
            2'd3: p = p3;
            default: p = p0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// User-side requests and change-stage / dispense handshake of the controller.
interface vend_controller_if;
    import vend_pkg::*;

    logic       coin_1;
    logic       coin_5;
    logic [1:0] product_sel;
    logic       buy;
    logic       cancel;
    logic       dispense_ack;
    amount_t    total_amount;
    amount_t    product_price;
    logic       vend_valid;
    logic       refund_valid;
    logic       coin_reject;
    logic       insufficient;

    // Environment side: coin mechanism, keypad and dispense logic.
    modport master (
        output coin_1, coin_5, product_sel, buy, cancel, dispense_ack,
        input  total_amount, product_price, vend_valid, refund_valid,
               coin_reject, insufficient
    );

    // Controller side.
    modport slave (
        input  coin_1, coin_5, product_sel, buy, cancel, dispense_ack,
        output total_amount, product_price, vend_valid, refund_valid,
               coin_reject, insufficient
    );

endinterface

// File: rtl/vend_timeout_counter.sv
// Idle-cycle counter for the COLLECT state; tc flags the last idle cycle.
module vend_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Count enabled idle cycles, saturating at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Caller gives its own clearing events priority over tc.
    assign tc = enable && (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Purchase controller: coin credit, selection, buy/cancel and dispense handshake.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_0        = 3,
    parameter int unsigned PRICE_1        = 5,
    parameter int unsigned PRICE_2        = 7,
    parameter int unsigned PRICE_3        = 12,
    parameter int unsigned MAX_TOTAL      = 15,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_controller_if.slave  bus
);

    state_t     state_q, state_d;
    amount_t    total_q, total_d;
    amount_t    price_q, price_d;
    logic       vend_q, refund_q, reject_q, insuf_q;
    logic       reject_d, insuf_d;
    logic [4:0] coin_val;
    logic [4:0] sum;
    logic       coin_fits;
    amount_t    sel_price;
    logic       tmo_clear;
    logic       tmo_tc;

    vend_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmo_clear),
        .enable (state_q == COLLECT),
        .tc     (tmo_tc)
    );

    // Next state, credit, price and pulse outputs; priority cancel > buy > coins > timeout.
    always_comb begin
        coin_val  = (bus.coin_1 ? COIN_1_VAL : 5'd0) + (bus.coin_5 ? COIN_5_VAL : 5'd0);
        sum       = {1'b0, total_q} + coin_val;
        coin_fits = (sum <= 5'(MAX_TOTAL));
        sel_price = price_lookup(bus.product_sel, 4'(PRICE_0), 4'(PRICE_1),
                                 4'(PRICE_2), 4'(PRICE_3));
        state_d   = state_q;
        total_d   = total_q;
        price_d   = price_q;
        reject_d  = 1'b0;
        insuf_d   = 1'b0;
        tmo_clear = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel && state_q == COLLECT) begin
                    state_d   = REFUND;
                    price_d   = '0;
                    reject_d  = (coin_val != '0);
                    tmo_clear = 1'b1;
                end else if (bus.buy && state_q == COLLECT && sel_price <= total_q) begin
                    state_d   = VEND;
                    price_d   = sel_price;
                    reject_d  = (coin_val != '0);
                    tmo_clear = 1'b1;
                end else begin
                    // A refused buy does not consume the cycle, so coins are still judged on credit.
                    if (bus.buy) begin
                        insuf_d   = 1'b1;
                        tmo_clear = 1'b1;
                    end
                    if (coin_val != '0) begin
                        if (coin_fits) begin
                            total_d   = sum[3:0];
                            state_d   = COLLECT;
                            tmo_clear = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    if (tmo_tc && !tmo_clear) begin
                        state_d = REFUND;
                        price_d = '0;
                    end
                end
            end
            VEND, REFUND: begin
                reject_d = (coin_val != '0);
                if (bus.dispense_ack) begin
                    state_d = IDLE;
                    total_d = '0;
                    price_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            total_q  <= '0;
            price_q  <= '0;
            vend_q   <= 1'b0;
            refund_q <= 1'b0;
            reject_q <= 1'b0;
            insuf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            price_q  <= price_d;
            vend_q   <= (state_d == VEND);
            refund_q <= (state_d == REFUND);
            reject_q <= reject_d;
            insuf_q  <= insuf_d;
        end
    end

    assign bus.total_amount  = total_q;
    assign bus.product_price = price_q;
    assign bus.vend_valid    = vend_q;
    assign bus.refund_valid  = refund_q;
    assign bus.coin_reject   = reject_q;
    assign bus.insufficient  = insuf_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed and random checks of vend_controller against a credit-level model.
module tb_vend_controller;

    localparam int unsigned T    = 8;
    localparam int          MAXT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vend_controller_if bus ();

    vend_controller #(
        .PRICE_0        (3),
        .PRICE_1        (5),
        .PRICE_2        (7),
        .PRICE_3        (12),
        .MAX_TOTAL      (15),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: credit held, price shown, which handshake is pending, idle run length.
    int m_credit, m_price, m_idle;
    bit m_vend, m_refund, m_reject, m_insuf;
    int price_tab[4] = '{3, 5, 7, 12};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_price = 0; m_idle = 0;
        m_vend = 0; m_refund = 0; m_reject = 0; m_insuf = 0;
    endtask

    task automatic model_step(input bit c1, input bit c5, input logic [1:0] sel,
                              input bit b, input bit cn, input bit ak);
        int cv;
        int p;
        bit taken;
        cv = (c1 ? 1 : 0) + (c5 ? 5 : 0);
        m_reject = 0; m_insuf = 0; taken = 0;
        if (m_vend || m_refund) begin
            m_reject = (cv > 0);
            if (ak) begin
                m_vend = 0; m_refund = 0; m_credit = 0; m_price = 0; m_idle = 0;
            end
        end else if (cn && m_credit > 0) begin
            m_reject = (cv > 0); m_refund = 1; m_price = 0; m_idle = 0;
        end else begin
            p = price_tab[sel];
            if (b && m_credit > 0 && p <= m_credit) begin
                m_vend = 1; m_price = p; m_reject = (cv > 0); m_idle = 0;
            end else begin
                if (b) begin
                    m_insuf = 1; m_idle = 0;
                end
                if (cv > 0) begin
                    if (m_credit + cv <= MAXT) begin
                        m_credit += cv; m_idle = 0; taken = 1;
                    end else begin
                        m_reject = 1;
                    end
                end
                if (m_credit > 0 && !b && !taken) begin
                    m_idle++;
                    if (m_idle == int'(T)) begin
                        m_refund = 1; m_price = 0; m_idle = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("total_amount",  {4'b0, bus.total_amount},  8'(m_credit));
        chk("product_price", {4'b0, bus.product_price}, 8'(m_price));
        chk("vend_valid",    {7'b0, bus.vend_valid},    {7'b0, m_vend});
        chk("refund_valid",  {7'b0, bus.refund_valid},  {7'b0, m_refund});
        chk("coin_reject",   {7'b0, bus.coin_reject},   {7'b0, m_reject});
        chk("insufficient",  {7'b0, bus.insufficient},  {7'b0, m_insuf});
        chk("valid_exclusive", {7'b0, bus.vend_valid & bus.refund_valid}, 8'd0);
        chk("change_nonneg", {7'b0, bus.product_price > bus.total_amount}, 8'd0);
    endtask

    // Called at a negedge; drives one cycle of inputs and checks after the posedge.
    task automatic step(input bit c1, input bit c5, input logic [1:0] sel,
                        input bit b, input bit cn, input bit ak);
        bus.coin_1 = c1; bus.coin_5 = c5; bus.product_sel = sel;
        bus.buy = b; bus.cancel = cn; bus.dispense_ack = ak;
        model_step(c1, c5, sel, b, cn, ak);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.coin_1 = 0; bus.coin_5 = 0; bus.product_sel = 2'd0;
        bus.buy = 0; bus.cancel = 0; bus.dispense_ack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Buy product 2 with two 5-coins.
        step(0, 1, 2'd0, 0, 0, 0);
        step(0, 1, 2'd0, 0, 0, 0);
        chk("total_10", {4'b0, bus.total_amount}, 8'd10);
        step(0, 0, 2'd2, 1, 0, 0);
        chk("vend_price_7", {4'b0, bus.product_price}, 8'd7);
        chk("change_3", {4'b0, bus.total_amount - bus.product_price}, 8'd3);
        step(0, 0, 2'd0, 0, 0, 1);
        chk("after_ack_total", {4'b0, bus.total_amount}, 8'd0);

        // Ceiling: 12 + 5 rejected; then 10 + 6 rejected as a pair.
        step(0, 1, 2'd0, 0, 0, 0);
        step(0, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0);
        step(0, 1, 2'd0, 0, 0, 0);
        chk("reject_at_12", {3'b0, bus.coin_reject, bus.total_amount}, 8'h1C);
        step(0, 0, 2'd0, 0, 1, 0);
        step(0, 0, 2'd0, 0, 0, 1);
        step(0, 1, 2'd0, 0, 0, 0);
        step(0, 1, 2'd0, 0, 0, 0);
        step(1, 1, 2'd0, 0, 0, 0);
        chk("reject_pair_at_10", {3'b0, bus.coin_reject, bus.total_amount}, 8'h1A);
        step(0, 0, 2'd0, 0, 1, 0);
        step(0, 0, 2'd0, 0, 0, 1);

        // Insufficient credit for product 3, at 5 and at 11.
        step(0, 1, 2'd0, 0, 0, 0);
        step(0, 0, 2'd3, 1, 0, 0);
        chk("insuf_at_5", {3'b0, bus.insufficient, bus.total_amount}, 8'h15);
        step(0, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0);
        step(0, 0, 2'd3, 1, 0, 0);
        chk("insuf_at_11", {3'b0, bus.insufficient, bus.total_amount}, 8'h1B);
        step(0, 0, 2'd0, 0, 1, 0);
        step(0, 0, 2'd0, 0, 0, 1);

        // Cancel with a coin at credit 6, coin during refund, then ack.
        step(0, 1, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 1, 0);
        chk("cancel_refund", {2'b0, bus.refund_valid, bus.coin_reject, bus.total_amount}, 8'h36);
        step(0, 1, 2'd0, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 1);
        chk("refund_done", {3'b0, bus.refund_valid, bus.total_amount}, 8'h00);

        // Timeout after T idle cycles; an accepted coin restarts the count.
        step(1, 0, 2'd0, 0, 0, 0);
        idle(int'(T) - 1);
        chk("no_timeout_yet", {7'b0, bus.refund_valid}, 8'd0);
        idle(1);
        chk("timeout_refund", {3'b0, bus.refund_valid, bus.total_amount}, 8'h11);
        step(0, 0, 2'd0, 0, 0, 1);
        step(1, 0, 2'd0, 0, 0, 0);
        idle(4);
        step(1, 0, 2'd0, 0, 0, 0);
        idle(int'(T) - 1);
        chk("restart_no_timeout", {7'b0, bus.refund_valid}, 8'd0);
        idle(1);
        chk("restart_timeout", {3'b0, bus.refund_valid, bus.total_amount}, 8'h12);
        step(0, 0, 2'd0, 0, 0, 1);

        // Asynchronous reset while vending (credit 9, price 5).
        step(0, 1, 2'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 0, 0, 0);
        step(0, 0, 2'd1, 1, 0, 0);
        chk("pre_reset_vend", {3'b0, bus.vend_valid, bus.total_amount}, 8'h19);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        step(1, 0, 2'd0, 0, 0, 0);

        // Random traffic; buy never shares a cycle with coins.
        for (int i = 0; i < 600; i++) begin
            int r;
            bit c1, c5, b, cn, ak;
            logic [1:0] sel;
            r   = int'($urandom_range(0, 99));
            sel = 2'($urandom_range(0, 3));
            c1 = 0; c5 = 0; b = 0; cn = 0; ak = 0;
            if (r < 15) c1 = 1;
            else if (r < 25) c5 = 1;
            else if (r < 28) begin c1 = 1; c5 = 1; end
            else if (r < 36) b = 1;
            else if (r < 40) cn = 1;
            else if (r < 42) begin cn = 1; c1 = 1; end
            ak = (m_vend || m_refund) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step(c1, c5, sel, b, cn, ak);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
